// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
//   Sequential AES InvSubBytes engine. A state vector is captured on the input
//   handshake and every byte is replaced by its FIPS-197 inverse S-box value,
//   `lanes` bytes per BUSY cycle, starting from byte 0 (LSB). The finished state
//   is presented on the output handshake and held until it is consumed.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in         state to substitute, byte i = in[i*8 +: 8]
//   in_valid   `in` is valid
//   in_ready   engine is idle and can accept a state
//   out        substituted state (meaningful only while out_valid=1)
//   out_valid  `out` holds a complete result
//   out_ready  consumer accepts `out`
module inv_sub_bytes_seq #(
  parameter int numbytes = 16,
  parameter int lanes    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*numbytes-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*numbytes-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W     = 8 * numbytes;
  localparam int CW    = 8 * lanes;
  localparam int ITERS = numbytes / lanes;
  localparam int IDX_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(ITERS - 1);
  localparam logic [W-1:0]     LANE_MASK = W'({CW{1'b1}});

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_s(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     work_q, work_d;

  logic [31:0]      shamt;
  logic [CW-1:0]    chunk;
  logic [CW-1:0]    subbed;
  logic [W-1:0]     merged;

  // Lane datapath: pull the current group of `lanes` bytes out of the working
  // register, substitute them, and splice them back in place. Shifting by a
  // multiple of the group width keeps only `lanes` S-box instances in hardware.
  always_comb begin
    shamt  = 32'(idx_q) * 32'(CW);
    chunk  = CW'(work_q >> shamt);
    subbed = '0;
    for (int l = 0; l < lanes; l++) begin
      subbed[l*8 +: 8] = inv_s(chunk[l*8 +: 8]);
    end
    merged = (work_q & ~(LANE_MASK << shamt)) | (W'(subbed) << shamt);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = merged;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  // Handshake outputs decode the registered state only, so neither in_valid
  // nor out_ready has a combinational path to an output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din  [3];
  logic [127:0] dout [3];
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference tables derived from GF(2^8) arithmetic, not copied from the design.
  logic [7:0] fwd_ref [256];
  logic [7:0] inv_ref [256];

  int lat_of [3] = '{4, 16, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.numbytes(16), .lanes(4)) u_l4 (
    .clk(clk), .reset(reset), .in(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  inv_sub_bytes_seq #(.numbytes(16), .lanes(1)) u_l1 (
    .clk(clk), .reset(reset), .in(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  inv_sub_bytes_seq #(.numbytes(16), .lanes(16)) u_l16 (
    .clk(clk), .reset(reset), .in(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] b, r, s;
    for (int v = 0; v < 256; v++) begin
      b = 8'h00;
      if (v != 0) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(8'(v), 8'(c)) == 8'h01) b = 8'(c);
        end
      end
      s = b;
      r = b;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      s = s ^ 8'h63;
      fwd_ref[v] = s;
      inv_ref[s] = 8'(v);
    end
  endtask

  function automatic logic [127:0] inv_state(input logic [127:0] x);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = inv_ref[x[i*8 +: 8]];
    return e;
  endfunction

  // Runs one complete transaction on instance d; called and returns at a negedge.
  task automatic xfer(input int d, input logic [127:0] data, input string tag,
                      output logic [127:0] res);
    int n;
    n = 0;
    while (!ir[d] && n < 64) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, 128'(ir[d]), 128'(1));
    din[d]  = data;
    iv[d]   = 1'b1;
    ordy[d] = 1'b0;
    @(negedge clk);
    iv[d]  = 1'b0;
    din[d] = {$urandom, $urandom, $urandom, $urandom};
    check({tag, "_irlow"}, 128'(ir[d]), 128'(0));
    n = 0;
    while (!ov[d] && n < 64) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 128'(n), 128'(lat_of[d]));
    res     = dout[d];
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    check({tag, "_ovclr"}, 128'(ov[d]), 128'(0));
    check({tag, "_irset"}, 128'(ir[d]), 128'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, data, exp;
    logic [7:0]   sv [16];
    logic [7:0]   uni_in  [3];
    logic [7:0]   uni_out [3];
    logic [127:0] q_in[$];
    logic [127:0] q_out[$];
    int           t_acc[$];
    int           k, n;

    for (int d = 0; d < 3; d++) begin
      din[d] = '0; iv[d] = 1'b0; ordy[d] = 1'b0;
    end
    reset = 1'b1;
    build_tables();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ov%0d", d), 128'(ov[d]), 128'(0));
      check($sformatf("rst_ir%0d", d), 128'(ir[d]), 128'(1));
      check($sformatf("rst_out%0d", d), dout[d], 128'(0));
    end
    reset = 1'b0;
    @(negedge clk);

    // Forward S-box of bytes 0..15 decodes back to 0..15.
    sv = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
           8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
    for (int i = 0; i < 16; i++) data[i*8 +: 8] = sv[i];
    xfer(0, data, "sbox_idx", res);
    check("sbox_idx_out", res, 128'h0f0e0d0c0b0a09080706050403020100);

    // Uniform states.
    uni_in  = '{8'h63, 8'h00, 8'h16};
    uni_out = '{8'h00, 8'h52, 8'hFF};
    for (int u = 0; u < 3; u++) begin
      xfer(0, {16{uni_in[u]}}, $sformatf("uni%0d", u), res);
      check($sformatf("uni%0d_out", u), res, {16{uni_out[u]}});
    end

    // Back-pressure: output held with new data and in_valid pending.
    data = {$urandom, $urandom, $urandom, $urandom};
    exp  = inv_state(data);
    din[0] = data; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    din[0] = ~data;
    n = 0;
    while (!ov[0] && n < 64) begin @(negedge clk); n++; end
    check("bp_lat", 128'(n), 128'(4));
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_out%0d", c), dout[0], exp);
      check($sformatf("bp_ov%0d", c), 128'(ov[0]), 128'(1));
      check($sformatf("bp_ir%0d", c), 128'(ir[0]), 128'(0));
      @(negedge clk);
    end
    ordy[0] = 1'b1; iv[0] = 1'b0;
    @(negedge clk);
    ordy[0] = 1'b0;
    check("bp_ovclr", 128'(ov[0]), 128'(0));
    check("bp_irset", 128'(ir[0]), 128'(1));

    // Exhaustive over byte values on all three lane configurations.
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 256; v++) begin
        xfer(d, {16{fwd_ref[v]}}, $sformatf("exh%0d_%0d", d, v), res);
        check($sformatf("exh%0d_%0d_out", d, v), res, {16{8'(v)}});
      end
    end

    // Random states.
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 20; r++) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        xfer(d, data, $sformatf("rnd%0d_%0d", d, r), res);
        check($sformatf("rnd%0d_%0d_out", d, r), res, inv_state(data));
      end
    end

    // Reset two cycles into BUSY.
    din[0] = {$urandom, $urandom, $urandom, $urandom};
    iv[0]  = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ov", 128'(ov[0]), 128'(0));
    check("mid_rst_out", dout[0], 128'(0));
    check("mid_rst_ir", 128'(ir[0]), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 128'(ir[0]), 128'(1));
    data = {$urandom, $urandom, $urandom, $urandom};
    xfer(0, data, "post_rst", res);
    check("post_rst_out", res, inv_state(data));

    // Back-to-back streaming with in_valid and out_ready held high.
    for (int i = 0; i < 6; i++) q_in.push_back({$urandom, $urandom, $urandom, $urandom});
    k = 0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 200 && q_out.size() < 6; c++) begin
      @(negedge clk);
      if (k < 6) begin din[0] = q_in[k]; iv[0] = 1'b1; end
      else iv[0] = 1'b0;
      if (ov[0]) q_out.push_back(dout[0]);
      if (ir[0] && iv[0]) begin t_acc.push_back(cyc); k++; end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    check("b2b_count", 128'(q_out.size()), 128'(6));
    check("b2b_acc", 128'(t_acc.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < q_out.size()) check($sformatf("b2b_out%0d", i), q_out[i], inv_state(q_in[i]));
      if (i > 0 && i < t_acc.size())
        check($sformatf("b2b_gap%0d", i), 128'(t_acc[i] - t_acc[i-1]), 128'(6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
